// File: rtl/sha256_round_ctrl.sv
// SHA-256 round controller: sequences one 512-bit block through an external
// compressor. It owns the message schedule (16-word sliding window), the
// round-constant ROM, the round index, and the eight digest registers.
module sha256_round_ctrl #(
  parameter int ROUNDS = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        FIRST,
  input  logic        W_VALID,
  output logic        W_READY,
  input  logic [31:0] W_DATA,
  output logic        LOAD,
  output logic        ROUND_EN,
  output logic [5:0]  I,
  output logic [31:0] K,
  output logic [31:0] W_OUT,
  input  logic [31:0] A_IN,
  input  logic [31:0] B_IN,
  input  logic [31:0] C_IN,
  input  logic [31:0] D_IN,
  input  logic [31:0] E_IN,
  input  logic [31:0] F_IN,
  input  logic [31:0] G_IN,
  input  logic [31:0] H_IN,
  output logic [31:0] H_OUT0,
  output logic [31:0] H_OUT1,
  output logic [31:0] H_OUT2,
  output logic [31:0] H_OUT3,
  output logic [31:0] H_OUT4,
  output logic [31:0] H_OUT5,
  output logic [31:0] H_OUT6,
  output logic [31:0] H_OUT7,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_ROUND, ST_ADD, ST_FIN} state_t;

  localparam logic [5:0] LAST_I = 6'(ROUNDS - 1);

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Small sigma functions of the message schedule.
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  i_q;
  logic [31:0] win_q [16];   // win_q[15] holds W[I-1], win_q[0] holds W[I-16]
  logic [31:0] h_q   [8];
  logic [31:0] w_exp;
  logic [31:0] w_cur;
  logic        in_msg;
  logic        round_fire;

  assign in_msg = (i_q < 6'd16);
  assign w_exp  = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];

  assign I      = i_q;
  assign K      = K_ROM[i_q];
  assign W_OUT  = w_cur;
  assign H_OUT0 = h_q[0];
  assign H_OUT1 = h_q[1];
  assign H_OUT2 = h_q[2];
  assign H_OUT3 = h_q[3];
  assign H_OUT4 = h_q[4];
  assign H_OUT5 = h_q[5];
  assign H_OUT6 = h_q[6];
  assign H_OUT7 = h_q[7];

  // Next-state and strobe decode; the word path selects input stream vs expansion.
  always_comb begin
    // NOTE: every output gets a default first so no path can leave a latch behind.
    state_d    = state_q;
    LOAD       = 1'b0;
    round_fire = 1'b0;
    W_READY    = 1'b0;
    DONE       = 1'b0;
    BUSY       = (state_q != ST_IDLE);
    w_cur      = in_msg ? W_DATA : w_exp;
    unique case (state_q)
      ST_IDLE: if (START) state_d = ST_LOAD;
      ST_LOAD: begin
        LOAD    = 1'b1;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        W_READY    = in_msg;
        round_fire = in_msg ? W_VALID : 1'b1;
        if (round_fire && (i_q == LAST_I)) state_d = ST_ADD;
      end
      ST_ADD:  state_d = ST_FIN;
      ST_FIN: begin
        DONE    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ROUND_EN = round_fire;

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Round index: cleared on load and after the last round, advances once per executed round.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      i_q <= '0;
    end else if (state_q == ST_LOAD) begin
      i_q <= '0;
    end else if (round_fire) begin
      i_q <= (i_q == LAST_I) ? 6'd0 : i_q + 6'd1;
    end
  end

  // Message schedule window: shifts in the word consumed by each executed round.
  always_ff @(posedge CLK) begin
    // NOTE: the window is cleared on reset so no word of an aborted block survives into the next one.
    if (RESET) begin
      for (int n = 0; n < 16; n++) win_q[n] <= '0;
    end else if (round_fire) begin
      for (int n = 0; n < 15; n++) win_q[n] <= win_q[n+1];
      win_q[15] <= w_cur;
    end
  end

  // Digest registers: IV load on a first-block start, feed-forward add after the last round.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int n = 0; n < 8; n++) h_q[n] <= IV[n];
    end else if (state_q == ST_IDLE && START && FIRST) begin
      for (int n = 0; n < 8; n++) h_q[n] <= IV[n];
    end else if (state_q == ST_ADD) begin
      h_q[0] <= h_q[0] + A_IN;
      h_q[1] <= h_q[1] + B_IN;
      h_q[2] <= h_q[2] + C_IN;
      h_q[3] <= h_q[3] + D_IN;
      h_q[4] <= h_q[4] + E_IN;
      h_q[5] <= h_q[5] + F_IN;
      h_q[6] <= h_q[6] + G_IN;
      h_q[7] <= h_q[7] + H_IN;
    end
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl. A behavioural compressor closes the
// loop so that complete digests of known messages can be checked.
module tb_sha256_round_ctrl;

  logic        CLK = 1'b0;
  logic        RESET, START, FIRST, W_VALID;
  logic        W_READY, LOAD, ROUND_EN, BUSY, DONE;
  logic [31:0] W_DATA, K, W_OUT;
  logic [5:0]  I;
  logic [31:0] A_IN, B_IN, C_IN, D_IN, E_IN, F_IN, G_IN, H_IN;
  logic [31:0] H_OUT0, H_OUT1, H_OUT2, H_OUT3, H_OUT4, H_OUT5, H_OUT6, H_OUT7;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] msg [16];
  logic [31:0] gw  [64];
  logic [31:0] h_obs [8];

  localparam logic [31:0] ABC_DIGEST [8] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };

  always #5 CLK = ~CLK;

  sha256_round_ctrl #(.ROUNDS(64)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .FIRST(FIRST),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA),
    .LOAD(LOAD), .ROUND_EN(ROUND_EN), .I(I), .K(K), .W_OUT(W_OUT),
    .A_IN(A_IN), .B_IN(B_IN), .C_IN(C_IN), .D_IN(D_IN),
    .E_IN(E_IN), .F_IN(F_IN), .G_IN(G_IN), .H_IN(H_IN),
    .H_OUT0(H_OUT0), .H_OUT1(H_OUT1), .H_OUT2(H_OUT2), .H_OUT3(H_OUT3),
    .H_OUT4(H_OUT4), .H_OUT5(H_OUT5), .H_OUT6(H_OUT6), .H_OUT7(H_OUT7),
    .BUSY(BUSY), .DONE(DONE)
  );

  assign h_obs[0] = H_OUT0;
  assign h_obs[1] = H_OUT1;
  assign h_obs[2] = H_OUT2;
  assign h_obs[3] = H_OUT3;
  assign h_obs[4] = H_OUT4;
  assign h_obs[5] = H_OUT5;
  assign h_obs[6] = H_OUT6;
  assign h_obs[7] = H_OUT7;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [31:0] bs0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bs1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] k_gold(input logic [5:0] idx);
    case (idx)
      6'd0:    return 32'h428a2f98;
      6'd16:   return 32'he49b69c1;
      6'd63:   return 32'hc67178f2;
      default: return 32'h0;
    endcase
  endfunction

  // Behavioural compressor driven by the controller's strobes.
  logic [31:0] ra, rb, rc, rd, re, rf, rg, rh, t1, t2;
  assign t1 = rh + bs1(re) + ((re & rf) ^ (~re & rg)) + K + W_OUT;
  assign t2 = bs0(ra) + ((ra & rb) ^ (ra & rc) ^ (rb & rc));
  assign {A_IN, B_IN, C_IN, D_IN, E_IN, F_IN, G_IN, H_IN} = {ra, rb, rc, rd, re, rf, rg, rh};

  always @(posedge CLK) begin
    if (LOAD) begin
      {ra, rb, rc, rd} <= {H_OUT0, H_OUT1, H_OUT2, H_OUT3};
      {re, rf, rg, rh} <= {H_OUT4, H_OUT5, H_OUT6, H_OUT7};
    end else if (ROUND_EN) begin
      {rb, rc, rd} <= {ra, rb, rc};
      {rf, rg, rh} <= {re, rf, rg};
      re <= rd + t1;
      ra <= t1 + t2;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic build_golden();
    for (int t = 0; t < 16; t++) gw[t] = msg[t];
    for (int t = 16; t < 64; t++) gw[t] = ss1(gw[t-2]) + gw[t-7] + ss0(gw[t-15]) + gw[t-16];
  endtask

  task automatic load_abc();
    for (int t = 0; t < 16; t++) msg[t] = 32'h0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
    build_golden();
  endtask

  task automatic check_abc(input string tag);
    for (int n = 0; n < 8; n++) check($sformatf("%s_h%0d", tag, n), h_obs[n], ABC_DIGEST[n]);
  endtask

  // Runs one block; optional random W_VALID gaps, stray START pulses, or a reset at round abort_at.
  task automatic run_block(input logic first, input bit gaps, input bit inject, input int abort_at,
                           output int lat, output int rounds, output int dones);
    int widx;
    bit xfer;
    bit fin;
    widx = 0; lat = 0; rounds = 0; dones = 0; fin = 0;
    @(negedge CLK);
    START = 1'b1;
    FIRST = first;
    @(posedge CLK);
    for (int c = 1; c <= 300 && !fin; c++) begin
      @(negedge CLK);
      START   = inject && (c == 20);
      FIRST   = inject && (c == 20);
      W_VALID = !(gaps && ($urandom_range(0, 2) == 0));
      W_DATA  = (widx < 16) ? msg[widx] : 32'h0;
      #1;
      if (DONE) begin
        dones++;
        lat = c;
        fin = 1'b1;
        if (inject) begin
          START = 1'b1;
          FIRST = 1'b1;
        end
      end
      if (ROUND_EN) begin
        rounds++;
        if (I == 6'd0 || I == 6'd16 || I == 6'd63) begin
          check($sformatf("k_i%0d", I), K, k_gold(I));
          check($sformatf("w_i%0d", I), W_OUT, gw[I]);
        end
      end
      xfer = W_READY && W_VALID;
      if (abort_at != 0 && ROUND_EN && I == 6'(abort_at)) begin
        RESET = 1'b1;
        fin   = 1'b1;
      end
      @(posedge CLK);
      if (xfer) widx++;
    end
    @(negedge CLK);
    START = 1'b0; FIRST = 1'b0; W_VALID = 1'b0; RESET = 1'b0;
    if (!fin) check("block_timeout", 32'(fin), 32'd1);
  endtask

  initial begin
    int lat, rounds, dones;
    RESET = 1'b1; START = 1'b0; FIRST = 1'b0; W_VALID = 1'b0; W_DATA = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_ready", 32'(W_READY), 32'd0);
    check("rst_strobes", {29'd0, LOAD, ROUND_EN, DONE}, 32'd0);
    check("rst_i", 32'(I), 32'd0);
    check("rst_h0", H_OUT0, 32'h6a09e667);
    check("rst_h7", H_OUT7, 32'h5be0cd19);

    // Single "abc" block, W_VALID held high.
    load_abc();
    run_block(1'b1, 1'b0, 1'b0, 0, lat, rounds, dones);
    check("abc_latency", 32'(lat), 32'd67);
    check("abc_rounds", 32'(rounds), 32'd64);
    check("abc_dones", 32'(dones), 32'd1);
    check_abc("abc");

    // Two-block message; a lone FIRST pulse between blocks must not reload the IV.
    for (int t = 0; t < 14; t++)
      msg[t] = {8'h61 + 8'(t), 8'h62 + 8'(t), 8'h63 + 8'(t), 8'h64 + 8'(t)};
    msg[14] = 32'h80000000;
    msg[15] = 32'h00000000;
    build_golden();
    run_block(1'b1, 1'b0, 1'b0, 0, lat, rounds, dones);
    check("two_b1_dones", 32'(dones), 32'd1);
    @(negedge CLK); FIRST = 1'b1;
    @(negedge CLK); FIRST = 1'b0;
    for (int t = 0; t < 15; t++) msg[t] = 32'h0;
    msg[15] = 32'h000001c0;
    build_golden();
    run_block(1'b0, 1'b0, 1'b0, 0, lat, rounds, dones);
    check("two_b2_dones", 32'(dones), 32'd1);
    check("two_h0", H_OUT0, 32'h248d6a61);
    check("two_h7", H_OUT7, 32'h19db06c1);

    // Random stalls on the input word stream.
    load_abc();
    run_block(1'b1, 1'b1, 1'b0, 0, lat, rounds, dones);
    check("gap_rounds", 32'(rounds), 32'd64);
    check("gap_dones", 32'(dones), 32'd1);
    check_abc("gap");

    // Reset at round 30 discards the block.
    run_block(1'b1, 1'b0, 1'b0, 30, lat, rounds, dones);
    for (int c = 0; c < 80; c++) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    check("abort_dones", 32'(dones), 32'd0);
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_i", 32'(I), 32'd0);
    check("abort_ready", 32'(W_READY), 32'd0);
    check("abort_h3", H_OUT3, 32'ha54ff53a);

    // Reset wins over START on the same edge.
    @(negedge CLK); RESET = 1'b1; START = 1'b1; FIRST = 1'b1;
    @(negedge CLK); RESET = 1'b0; START = 1'b0; FIRST = 1'b0;
    #1;
    check("rst_prio_busy", 32'(BUSY), 32'd0);
    run_block(1'b1, 1'b0, 1'b0, 0, lat, rounds, dones);
    check("post_abort_dones", 32'(dones), 32'd1);
    check_abc("post_abort");

    // START pulsed during ROUND and at FIN is ignored.
    run_block(1'b1, 1'b0, 1'b1, 0, lat, rounds, dones);
    #1;
    check("inject_idle", 32'(BUSY), 32'd0);
    check("inject_latency", 32'(lat), 32'd67);
    check("inject_dones", 32'(dones), 32'd1);
    dones = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    check("inject_no_extra_done", 32'(dones), 32'd0);
    check_abc("inject");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_round_ctrl.md
SHA256_ROUND_CTRL -- requirements
Module: sha256_round_ctrl

Interface
REQ-001 Parameter: ROUNDS, default 64, rounds per block; values below 64 are for test only.
REQ-002 Port: CLK  in  1  clock; all state changes on rising edge.
REQ-003 Port: RESET  in  1  reset, synchronous, active-high.
REQ-004 Port: START  in  1  begin one block; sampled only in IDLE.
REQ-005 Port: FIRST  in  1  sampled with START; 1 = load standard IV, 0 = chain from current digest.
REQ-006 Port: W_VALID / W_READY / W_DATA  in / out / 1,1,32  message word stream, words 0..15, transfer when both high.
REQ-007 Port: LOAD  out  1  compressor loads working vars from H_OUT this cycle.
REQ-008 Port: ROUND_EN  out  1  compressor executes one round this cycle.
REQ-009 Port: I  out  6  current round index.
REQ-010 Port: K  out  32  round constant for I (internal 64-entry ROM, FIPS 180-4).
REQ-011 Port: W_OUT  out  32  message word for round I (words 0..15 pass-through, 16..63 expanded internally).
REQ-012 Port: A_IN..H_IN  in  8x32  compressor working vars after final round.
REQ-013 Port: H_OUT0..H_OUT7  out  8x32  digest registers.
REQ-014 Port: BUSY  out  1  high outside IDLE; DONE  out  1  one-cycle pulse when digest updated.

Function
REQ-015 States: IDLE, LOAD, ROUND, ADD, FIN.
REQ-016 IDLE: START=1 -> LOAD; if FIRST=1, H_OUT0..7 set to IV 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19 on the same edge.
REQ-017 LOAD: LOAD=1 for exactly one cycle, I=0, then -> ROUND.
REQ-018 ROUND, I<16: W_READY=1; ROUND_EN=W_VALID; W_OUT=W_DATA; I increments only on transfer.
REQ-019 ROUND, I>=16: W_READY=0, ROUND_EN=1 every cycle, W_OUT=s1(W[I-2])+W[I-7]+s0(W[I-15])+W[I-16] mod 2^32 from a 16-entry sliding window.
REQ-020 Round I=ROUNDS-1 executed -> ADD; I never wraps past 63.
REQ-021 ADD: H_OUTn <= H_OUTn + {A..H}_IN mod 2^32, one cycle, -> FIN.
REQ-022 FIN: DONE=1 one cycle, -> IDLE.
REQ-023 Minimum START-to-DONE latency ROUNDS+3 cycles with W_VALID held high.
REQ-024 START outside IDLE ignored; FIRST ignored without START.
REQ-025 W_VALID stall at any I<16 holds I, window, ROUND_EN=0; no round skipped or repeated.
REQ-026 LOAD, ROUND_EN, DONE mutually exclusive.
REQ-027 W_READY=0 in every state except ROUND with I<16.

Reset
REQ-028 RESET=1 at any edge, including mid-block: state IDLE, I=0, all strobes/BUSY/W_READY=0, H_OUT0..7=IV, window cleared; in-flight block discarded.
REQ-029 RESET has priority over START on the same edge.

Verification
REQ-030 FIRST=1, message "abc" padded, W_VALID constant -> DONE at cycle 67, H_OUT0..7=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-031 Two-block 448-bit "abcdbcdecdef..nopq": block 1 FIRST=1, block 2 FIRST=0 -> H_OUT0=248d6a61, H_OUT7=19db06c1.
REQ-032 Random W_VALID gaps on words 0..15 -> same digest as REQ-030; I count of ROUND_EN pulses =64.
REQ-033 RESET at round 30 then new FIRST=1 "abc" block -> H_OUT matches REQ-030, no DONE from aborted block.
REQ-034 START pulsed during ROUND and at FIN -> ignored, single DONE, digest unchanged from single-block result.
REQ-035 Check K and W_OUT at I=0, 16, 63 vs golden model each cycle ROUND_EN=1.
